// File: rtl/dispense_pkg.sv
// Shared encodings for the dispense arbiter: command types, FSM states, channel IDs.
package dispense_pkg;

  // Command codes double as the counter index within a channel.
  typedef enum logic [1:0] {
    CMD_BOTTLE = 2'b00,
    CMD_R1     = 2'b01,
    CMD_R5     = 2'b10
  } cmd_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StFault
  } state_e;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Priority within a channel: bottle first, then the larger coin.
  // pend bit order matches the command code: [0] bottle, [1] R1, [2] R5.
  function automatic cmd_type_e pick_type(input logic [2:0] pend);
    if (pend[0]) return CMD_BOTTLE;
    if (pend[2]) return CMD_R5;
    return CMD_R1;
  endfunction

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down counter of outstanding requests for one channel/command pair.
module pending_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic            sat_hit_o
);

  localparam logic [CntW-1:0] MaxCount = '1;

  logic [CntW-1:0] count_q, count_d;

  // Next count; simultaneous inc and dec cancel, so only a lone inc can saturate.
  always_comb begin
    count_d   = count_q;
    sat_hit_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == MaxCount) begin
        sat_hit_o = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dispense_arbiter.sv
// Round-robin arbiter sharing one dispense mechanism between soda channels A and B.
module dispense_arbiter
  import dispense_pkg::*;
#(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bottle_a,
  input  logic       r1_a,
  input  logic       r5_a,
  input  logic       bottle_b,
  input  logic       r1_b,
  input  logic       r5_b,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [1:0] cmd_type,
  output logic       cmd_ch,
  output logic       busy_a,
  output logic       busy_b,
  output logic       ovf_a,
  output logic       ovf_b,
  output logic       fault
);

  localparam int unsigned TmrW = 16;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  // Flat index: channel*3 + command code.
  logic [5:0] req, dec, nz, sat;
  logic [CNT_W-1:0] cnt [6];

  assign req = {r5_b, r1_b, bottle_b, r5_a, r1_a, bottle_a};

  for (genvar i = 0; i < 6; i++) begin : g_cnt
    pending_counter #(
      .CntW(CNT_W)
    ) u_cnt (
      .clk_i    (clk),
      .rst_ni   (reset),
      .inc_i    (req[i]),
      .dec_i    (dec[i]),
      .count_o  (cnt[i]),
      .sat_hit_o(sat[i])
    );
    assign nz[i] = |cnt[i];
  end

  state_e          state_q, state_d;
  cmd_type_e       cmd_type_q, cmd_type_d, sel_type;
  logic            cmd_ch_q, cmd_ch_d, sel_ch;
  logic            cmd_valid_q, cmd_valid_d;
  logic            fault_q, fault_d;
  logic            rr_q, rr_d;
  logic            ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [2:0]      dec_idx;

  // Channel choice: preferred channel if it has work, else the other one.
  always_comb begin
    if (rr_q == CH_A) begin
      sel_ch = (|nz[2:0]) ? CH_A : CH_B;
    end else begin
      sel_ch = (|nz[5:3]) ? CH_B : CH_A;
    end
    sel_type = pick_type((sel_ch == CH_B) ? nz[5:3] : nz[2:0]);
  end

  // FSM next state, registered outputs, and the decrement strobe on ack.
  always_comb begin
    state_d     = state_q;
    cmd_type_d  = cmd_type_q;
    cmd_ch_d    = cmd_ch_q;
    cmd_valid_d = 1'b0;
    fault_d     = fault_q;
    rr_d        = rr_q;
    timer_d     = timer_q;
    ovf_a_d     = ovf_a_q | (|sat[2:0]);
    ovf_b_d     = ovf_b_q | (|sat[5:3]);
    dec         = '0;
    dec_idx     = (cmd_ch_q ? 3'd3 : 3'd0) + {1'b0, cmd_type_q};
    unique case (state_q)
      StIdle: begin
        if (|nz) begin
          state_d     = StIssue;
          cmd_valid_d = 1'b1;
          cmd_type_d  = sel_type;
          cmd_ch_d    = sel_ch;
          timer_d     = '0;
        end
      end
      StIssue: begin
        if (cmd_ack) begin
          dec[dec_idx] = 1'b1;
          rr_d         = ~cmd_ch_q;
          state_d      = StGap;
        end else if (timer_q == TmrLast) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else begin
          cmd_valid_d = 1'b1;
          timer_d     = timer_q + 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      StFault: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All control and output state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cmd_type_q  <= CMD_BOTTLE;
      cmd_ch_q    <= CH_A;
      cmd_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      rr_q        <= CH_A;
      timer_q     <= '0;
      ovf_a_q     <= 1'b0;
      ovf_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_type_q  <= cmd_type_d;
      cmd_ch_q    <= cmd_ch_d;
      cmd_valid_q <= cmd_valid_d;
      fault_q     <= fault_d;
      rr_q        <= rr_d;
      timer_q     <= timer_d;
      ovf_a_q     <= ovf_a_d;
      ovf_b_q     <= ovf_b_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_ch    = cmd_ch_q;
  assign fault     = fault_q;
  assign ovf_a     = ovf_a_q;
  assign ovf_b     = ovf_b_q;
  assign busy_a    = |nz[2:0];
  assign busy_b    = |nz[5:3];

endmodule

// File: doc/dispense_arbiter.md
# dispense_arbiter

Shares one physical dispense mechanism (bottle chute plus coin hopper) between two soda-vending FSM channels, A and B. Each channel emits single-cycle bottle, R1 and R5 pulses. The arbiter counts them as pending work and issues them one at a time to the mechanism over a valid/ack handshake. Channels are served round-robin, and the arbiter flags a fault if the mechanism stops acknowledging.

## Interface
- CNT_W, 4, width of each pending counter; saturates at 2^CNT_W-1
- TIMEOUT, 255, cycles in ISSUE without ack before FAULT; range 1..65535
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- bottle_a, r1_a, r5_a  in  1 each  channel A request pulses; any combination may be high in one cycle
- bottle_b, r1_b, r5_b  in  1 each  channel B request pulses
- cmd_ack  in  1  single-cycle pulse from the mechanism: current command completed
- cmd_valid  out  1  command presented; held until ack or timeout
- cmd_type  out  2  00 bottle, 01 R1, 10 R5; 11 is never driven
- cmd_ch  out  1  0 = A, 1 = B
- busy_a, busy_b  out  1 each  channel has any nonzero pending counter
- ovf_a, ovf_b  out  1 each  sticky: a request arrived while its counter was saturated
- fault  out  1  sticky: ack timeout occurred

## Operation
- Six pending counters, one per {A,B} × {bottle,R1,R5}.
  - A request pulse increments its counter.
  - An ack decrements the counter of the command in flight.
  - Increment and decrement in the same cycle on the same counter: value unchanged.
  - Increment at max: value holds and the channel's ovf sets.
  - Decrement never underflows, because only a nonzero counter is ever issued.
- Selection within a channel: bottle, then R5, then R1. The bottle leaves before change, and larger coins before smaller ones.
- Selection between channels:
  - A round-robin pointer rr (reset = A) names the preferred channel.
  - If the preferred channel has nothing pending, the other channel is served.
  - On each ack, rr moves to the channel not just served.
- FSM states:
  - IDLE: cmd_valid=0. If any counter is nonzero, register cmd_type/cmd_ch from the selection and go to ISSUE. Otherwise stay.
  - ISSUE: cmd_valid=1 and cmd_type/cmd_ch stable; timer increments each cycle.
    - cmd_ack: decrement the selected counter, update rr, go to GAP.
    - Timer reaches TIMEOUT-1 with no ack: go to FAULT.
  - GAP: cmd_valid=0 for exactly one cycle, then IDLE.
  - FAULT: cmd_valid=0 and fault=1. Counters keep accepting increments, saturating and setting ovf as usual. Exit only via reset.
- cmd_ack outside ISSUE is ignored; no counter changes.
- Reset values: all outputs 0, all counters 0, rr=A, state IDLE, timer 0.
- Reset mid-ISSUE:
  - cmd_valid drops asynchronously.
  - Pending work is discarded.
  - The in-flight command is not completed.

## Timing
- Request pulse at cycle t: counter updates at edge t+1, busy_x=1 from t+1, cmd_valid=1 from t+2 when the FSM is in IDLE.
- cmd_ack at cycle k in ISSUE: counter updates at edge k+1, cmd_valid=0 during k+1 (GAP). The next command's cmd_valid is earliest at k+3.
- Maximum issue rate: one command per 3 cycles with zero-latency ack.
- Timeout: cmd_valid high for exactly TIMEOUT cycles, then fault=1 on the next cycle.
- Every output is registered; there is no combinational path from input to output.

## Structure
- Package dispense_pkg holds:
  - cmd_type encodings (CMD_BOTTLE, CMD_R1, CMD_R5)
  - FSM state encoding (IDLE, ISSUE, GAP, FAULT)
  - channel IDs
- One sub-module, pending_counter: CNT_W saturating up/down counter with inc, dec, count and sat_hit outputs. The arbiter instantiates it six times.
- The arbiter itself contains the selection logic, rr pointer, FSM and timeout timer.

## Test plan
- Single bottle_a pulse at t=0 with immediate ack → cmd_valid rises at t=2 with type 00, ch 0; busy_a=0 after the ack edge.
- Channel A gets bottle_a and r5_a in the same cycle, then four r1_a pulses; ack each command after 2 cycles → issue order is bottle, R5, R1, R1, R1, R1; all counters end at 0.
- Both channels get 2 bottles each, pulsed simultaneously → ch sequence A, B, A, B.
- ack never arrives with TIMEOUT=10 → cmd_valid is high for 10 cycles, then fault=1 and cmd_valid=0. Further r1_b pulses still raise busy_b, and no further command issues.
- 17 r1_a pulses with CNT_W=4 and no ack → counter holds at 15 and ovf_a=1. After 15 acks, busy_a=0.
- reset low while in ISSUE with pending counts → all outputs and counters are 0 immediately. After release, a new bottle_b request issues normally with ch 1.
